// File: rtl/s55dram_w64d1042.sv
// s55dram_w64d1042: 64 x 1042 true dual-port synchronous SRAM behavioural model
// Latency: 1 cycle read (registered QA/QB); writes commit at the rising edge.
// Backpressure: none; both ports accept one access every cycle with no bubbles.
//
// Ports:
//   clk            single clock, all activity on its rising edge
//   rst            asynchronous active-high reset, clears QA/QB only
//   CENA/CENB      chip enable, active low
//   WENA/WENB      write enable, active low (0 = write, 1 = read)
//   AA/AB          word address, values >= DEPTH are out of range
//   DA/DB          write data
//   QA/QB          registered read data
module s55dram_w64d1042 #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 1042,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  // port A
  input  logic                  CENA,
  input  logic                  WENA,
  input  logic [ADDR_WIDTH-1:0] AA,
  input  logic [DATA_WIDTH-1:0] DA,
  output logic [DATA_WIDTH-1:0] QA,
  // port B
  input  logic                  CENB,
  input  logic                  WENB,
  input  logic [ADDR_WIDTH-1:0] AB,
  input  logic [DATA_WIDTH-1:0] DB,
  output logic [DATA_WIDTH-1:0] QB
);

  // One extra bit so the range compare also works when DEPTH == 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  // Storage array; the model starts with every word cleared.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

  // Registered read data
  logic [DATA_WIDTH-1:0] qa_q, qa_d;
  logic [DATA_WIDTH-1:0] qb_q, qb_d;

  // Per-port decode
  logic in_range_a, in_range_b;
  logic wr_a, wr_b;
  logic rd_a, rd_b;
  logic same_addr;

  assign in_range_a = ({1'b0, AA} < DEPTH_W);
  assign in_range_b = ({1'b0, AB} < DEPTH_W);
  assign same_addr  = (AA == AB);

  assign rd_a = !CENA &&  WENA;
  assign rd_b = !CENB &&  WENB;

  // Out-of-range writes are dropped. When both ports write the same word,
  // port A has priority and port B's write is discarded.
  assign wr_a = !CENA && !WENA && in_range_a;
  assign wr_b = !CENB && !WENB && in_range_b && !(wr_a && same_addr);

  // Memory update. Reset is in the sensitivity list only so it blocks
  // accesses while asserted; it never alters the stored contents.
  always_ff @(posedge clk or posedge rst) begin
    if (!rst) begin
      if (wr_a) begin
        mem_q[AA] <= DA;
      end
      if (wr_b) begin
        mem_q[AB] <= DB;
      end
    end
  end

  // Read-data next state. The array is sampled before this edge's writes
  // land, so a read colliding with a write returns the old contents.
  // Writes and idle cycles leave Q untouched (no write-through).
  always_comb begin
    qa_d = qa_q;
    if (rd_a) begin
      qa_d = in_range_a ? mem_q[AA] : '0;
    end
  end

  always_comb begin
    qb_d = qb_q;
    if (rd_b) begin
      qb_d = in_range_b ? mem_q[AB] : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qa_q <= '0;
      qb_q <= '0;
    end else begin
      qa_q <= qa_d;
      qb_q <= qb_d;
    end
  end

  assign QA = qa_q;
  assign QB = qb_q;

endmodule

// File: tb/tb_s55dram_w64d1042.sv
// Self-checking bench for s55dram_w64d1042: scenario tasks push expected read
// data into per-port queues when a read is driven, and pop/compare after the edge.
module tb_s55dram_w64d1042;

  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic        CENA = 1'b1;
  logic        WENA = 1'b1;
  logic [10:0] AA   = '0;
  logic [63:0] DA   = '0;
  logic [63:0] QA;
  logic        CENB = 1'b1;
  logic        WENB = 1'b1;
  logic [10:0] AB   = '0;
  logic [63:0] DB   = '0;
  logic [63:0] QB;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_a[$];
  logic [63:0] exp_b[$];
  logic [63:0] e;

  s55dram_w64d1042 dut (
    .clk (clk),
    .rst (rst),
    .CENA(CENA),
    .WENA(WENA),
    .AA  (AA),
    .DA  (DA),
    .QA  (QA),
    .CENB(CENB),
    .WENB(WENB),
    .AB  (AB),
    .DB  (DB),
    .QB  (QB)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    CENA = 1'b1; WENA = 1'b1;
    CENB = 1'b1; WENB = 1'b1;
  endtask

  function automatic logic [63:0] fdat(int i);
    return {32'(i) ^ 32'hC0DE_0000, 32'(i) * 32'h9E37_79B9};
  endfunction

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++; if (QA !== 64'h0) begin failures++; $display("FAIL reset_init_qa QA=%h exp=%h", QA, 64'h0); end
    checks++; if (QB !== 64'h0) begin failures++; $display("FAIL reset_init_qb QB=%h exp=%h", QB, 64'h0); end
    tick();
    rst = 1'b0;
    // Load a known word and read it on both ports.
    CENA = 0; WENA = 0; AA = 11'd2; DA = 64'h0123_4567_89AB_CDEF;
    tick();
    CENA = 0; WENA = 1; AA = 11'd2; exp_a.push_back(64'h0123_4567_89AB_CDEF);
    CENB = 0; WENB = 1; AB = 11'd2; exp_b.push_back(64'h0123_4567_89AB_CDEF);
    tick();
    e = exp_a.pop_front();
    checks++; if (QA !== e) begin failures++; $display("FAIL reset_pre_qa QA=%h exp=%h", QA, e); end
    e = exp_b.pop_front();
    checks++; if (QB !== e) begin failures++; $display("FAIL reset_pre_qb QB=%h exp=%h", QB, e); end
    // Write mem[5] so it can be checked to survive reset.
    CENA = 0; WENA = 0; AA = 11'd5; DA = {16{4'hA}};
    CENB = 1;
    tick();
    idle();
    // Assert reset mid-cycle: outputs clear before the next edge.
    #3 rst = 1'b1;
    #1;
    checks++; if (QA !== 64'h0) begin failures++; $display("FAIL reset_async_qa QA=%h exp=%h", QA, 64'h0); end
    checks++; if (QB !== 64'h0) begin failures++; $display("FAIL reset_async_qb QB=%h exp=%h", QB, 64'h0); end
    // Accesses during reset are blocked.
    CENA = 0; WENA = 0; AA = 11'd5; DA = {16{4'hB}};
    CENB = 0; WENB = 1; AB = 11'd5;
    tick();
    checks++; if (QB !== 64'h0) begin failures++; $display("FAIL reset_blocked_qb QB=%h exp=%h", QB, 64'h0); end
    idle();
    rst = 1'b0;
    CENB = 0; WENB = 1; AB = 11'd5; exp_b.push_back({16{4'hA}});
    tick();
    e = exp_b.pop_front();
    checks++; if (QB !== e) begin failures++; $display("FAIL reset_mem_kept QB=%h exp=%h", QB, e); end
    idle();
  endtask

  task automatic test_basic();
    idle();
    CENA = 0; WENA = 0; AA = 11'd0; DA = 64'hDEAD_BEEF_0000_0001;
    tick();
    CENA = 0; WENA = 0; AA = 11'd1041; DA = 64'hDEAD_BEEF_0000_0002;
    CENB = 0; WENB = 1; AB = 11'd0; exp_b.push_back(64'hDEAD_BEEF_0000_0001);
    tick();
    e = exp_b.pop_front();
    checks++; if (QB !== e) begin failures++; $display("FAIL basic_addr0 QB=%h exp=%h", QB, e); end
    CENA = 1;
    CENB = 0; WENB = 1; AB = 11'd1041; exp_b.push_back(64'hDEAD_BEEF_0000_0002);
    tick();
    e = exp_b.pop_front();
    checks++; if (QB !== e) begin failures++; $display("FAIL basic_addr1041 QB=%h exp=%h", QB, e); end
    idle();
  endtask

  task automatic test_rw_collision();
    idle();
    CENA = 0; WENA = 0; AA = 11'd7; DA = {16{4'h1}};
    tick();
    CENA = 0; WENA = 0; AA = 11'd7; DA = {16{4'h2}};
    CENB = 0; WENB = 1; AB = 11'd7; exp_b.push_back({16{4'h1}});
    tick();
    e = exp_b.pop_front();
    checks++; if (QB !== e) begin failures++; $display("FAIL rw_old_data QB=%h exp=%h", QB, e); end
    CENA = 1;
    CENB = 0; WENB = 1; AB = 11'd7; exp_b.push_back({16{4'h2}});
    tick();
    e = exp_b.pop_front();
    checks++; if (QB !== e) begin failures++; $display("FAIL rw_new_data QB=%h exp=%h", QB, e); end
    // Mirror case: B writes while A reads.
    CENB = 0; WENB = 0; AB = 11'd7; DB = {16{4'h7}};
    CENA = 0; WENA = 1; AA = 11'd7; exp_a.push_back({16{4'h2}});
    tick();
    e = exp_a.pop_front();
    checks++; if (QA !== e) begin failures++; $display("FAIL rw_b_old_data QA=%h exp=%h", QA, e); end
    CENB = 1;
    CENA = 0; WENA = 1; AA = 11'd7; exp_a.push_back({16{4'h7}});
    tick();
    e = exp_a.pop_front();
    checks++; if (QA !== e) begin failures++; $display("FAIL rw_b_new_data QA=%h exp=%h", QA, e); end
    idle();
  endtask

  task automatic test_ww_collision();
    idle();
    CENA = 0; WENA = 0; AA = 11'd9; DA = {16{4'h3}};
    CENB = 0; WENB = 0; AB = 11'd9; DB = {16{4'h4}};
    tick();
    CENA = 0; WENA = 1; AA = 11'd9; exp_a.push_back({16{4'h3}});
    CENB = 0; WENB = 1; AB = 11'd9; exp_b.push_back({16{4'h3}});
    tick();
    e = exp_a.pop_front();
    checks++; if (QA !== e) begin failures++; $display("FAIL ww_a_wins_qa QA=%h exp=%h", QA, e); end
    e = exp_b.pop_front();
    checks++; if (QB !== e) begin failures++; $display("FAIL ww_a_wins_qb QB=%h exp=%h", QB, e); end
    idle();
  endtask

  task automatic test_hold_oor();
    idle();
    CENA = 0; WENA = 0; AA = 11'd3; DA = {16{4'h5}};
    tick();
    CENA = 0; WENA = 1; AA = 11'd3; exp_a.push_back({16{4'h5}});
    CENB = 0; WENB = 1; AB = 11'd3; exp_b.push_back({16{4'h5}});
    tick();
    e = exp_a.pop_front();
    checks++; if (QA !== e) begin failures++; $display("FAIL hold_read_qa QA=%h exp=%h", QA, e); end
    e = exp_b.pop_front();
    checks++; if (QB !== e) begin failures++; $display("FAIL hold_read_qb QB=%h exp=%h", QB, e); end
    // Port B idle with a different address: QB must hold.
    CENA = 1;
    CENB = 1; WENB = 1; AB = 11'd0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (QB !== {16{4'h5}}) begin failures++; $display("FAIL hold_idle_%0d QB=%h exp=%h", k, QB, {16{4'h5}}); end
    end
    // Out-of-range write is dropped; out-of-range read returns zero.
    CENA = 0; WENA = 0; AA = 11'd1500; DA = {16{4'h6}};
    tick();
    checks++; if (QA !== {16{4'h5}}) begin failures++; $display("FAIL write_no_qa_change QA=%h exp=%h", QA, {16{4'h5}}); end
    CENA = 1;
    CENB = 0; WENB = 1; AB = 11'd1500; exp_b.push_back(64'h0);
    tick();
    e = exp_b.pop_front();
    checks++; if (QB !== e) begin failures++; $display("FAIL oor_read QB=%h exp=%h", QB, e); end
    // A 1500-word aliasing onto a real word would corrupt address 458.
    CENB = 0; WENB = 1; AB = 11'd458; exp_b.push_back(64'h0);
    tick();
    e = exp_b.pop_front();
    checks++; if (QB !== e) begin failures++; $display("FAIL oor_no_alias QB=%h exp=%h", QB, e); end
    idle();
  endtask

  task automatic test_fifo();
    int n;
    n = 1042 + 20;
    idle();
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        CENA = 0; WENA = 0; AA = 11'(i % 1042); DA = fdat(i);
      end else begin
        CENA = 1; WENA = 1;
      end
      if (i > 0) begin
        CENB = 0; WENB = 1; AB = 11'((i - 1) % 1042);
        exp_b.push_back(fdat(i - 1));
      end else begin
        CENB = 1; WENB = 1;
      end
      tick();
      if (i > 0) begin
        e = exp_b.pop_front();
        checks++;
        if (QB !== e) begin
          failures++;
          $display("FAIL fifo_word_%0d QB=%h exp=%h", i - 1, QB, e);
        end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rw_collision();
    test_ww_collision();
    test_hold_oor();
    test_fifo();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
